// File: rtl/axis_width_down.sv
// axis_width_down
//   Splits each wide AXI-Stream input beat into R = C_S_DATA_WIDTH/C_M_DATA_WIDTH narrow
//   output beats, least-significant lane first. On packet-final input beats, trailing
//   subwords whose strobes are all zero are dropped, so the packet ends early.
//   Sustains one output beat per cycle: the next input is taken on the same edge that
//   retires the final subword of the current one.
//
// Ports
//   clk, resetn           clock (rising edge), synchronous active-low reset
//   s_axis_t*             wide input stream (tvalid/tready/tdata/tstrb/tlast)
//   m_axis_t*             narrow output stream (tvalid/tready/tdata/tstrb/tlast)

module axis_width_down #(
  parameter int unsigned C_S_DATA_WIDTH = 64,
  parameter int unsigned C_M_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_S_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                          m_axis_tlast
);

  localparam int unsigned Ratio  = C_S_DATA_WIDTH / C_M_DATA_WIDTH;
  localparam int unsigned IdxW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int unsigned SStrbW = C_S_DATA_WIDTH / 8;
  localparam int unsigned MStrbW = C_M_DATA_WIDTH / 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  logic [C_S_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [SStrbW-1:0]         hold_strb_q, hold_strb_d;
  logic                      hold_last_q, hold_last_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [IdxW-1:0]           sub_idx_q, sub_idx_d;
  logic [IdxW-1:0]           fin_idx_q, fin_idx_d;

  logic            final_sub;
  logic            accept;
  logic [IdxW-1:0] cap_fin_idx;

  assign final_sub     = (sub_idx_q == fin_idx_q);
  assign s_axis_tready = resetn && (!hold_valid_q || (m_axis_tready && final_sub));
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = hold_valid_q;
  assign m_axis_tdata  = hold_data_q[int'(sub_idx_q) * C_M_DATA_WIDTH +: C_M_DATA_WIDTH];
  assign m_axis_tstrb  = hold_strb_q[int'(sub_idx_q) * MStrbW +: MStrbW];
  assign m_axis_tlast  = hold_valid_q && hold_last_q && final_sub;

  // Last subword to emit for the beat being captured: all of them for non-final beats,
  // otherwise the highest lane carrying any strobe (lane 0 if none do).
  always_comb begin
    cap_fin_idx = LastIdx;
    if (s_axis_tlast) begin
      cap_fin_idx = '0;
      for (int unsigned k = 0; k < Ratio; k++) begin
        if (s_axis_tstrb[k*MStrbW +: MStrbW] != '0) begin
          cap_fin_idx = IdxW'(k);
        end
      end
    end
  end

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_strb_d  = hold_strb_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    sub_idx_d    = sub_idx_q;
    fin_idx_d    = fin_idx_q;
    if (accept) begin
      // An accept while full implies the final subword is retiring on this edge.
      hold_data_d  = s_axis_tdata;
      hold_strb_d  = s_axis_tstrb;
      hold_last_d  = s_axis_tlast;
      hold_valid_d = 1'b1;
      sub_idx_d    = '0;
      fin_idx_d    = cap_fin_idx;
    end else if (hold_valid_q && m_axis_tready) begin
      if (final_sub) begin
        hold_valid_d = 1'b0;
        sub_idx_d    = '0;
      end else begin
        sub_idx_d = sub_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_data_q  <= '0;
      hold_strb_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      sub_idx_q    <= '0;
      fin_idx_q    <= LastIdx;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_strb_q  <= hold_strb_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      sub_idx_q    <= sub_idx_d;
      fin_idx_q    <= fin_idx_d;
    end
  end

endmodule
